cdb_arbiter: RTL and testbench

- Responder end of the CDB request/broadcast handshake.
- Collects `cdb_request`/`cdb_out` pairs from every functional unit (ALU, JUMP, LS, MUL, DIV).
- Each cycle, grants at most one requester by round-robin and drives the registered Common Data Bus (ON bit + FU tag + RS tag + data) that all RS lines, the register-status table and the requesting units snoop.
- A unit learns it has been served only by seeing its own FU tag on the bus with ON=1.

---
 rtl/cdb_arbiter.sv | 156 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: responder end of the CDB request/broadcast handshake.
// Picks at most one requesting functional unit per cycle by round-robin
// (unit order 0=ALU, 1=JUMP, 2=LS, 3=MUL, 4=DIV) and drives the registered
// Common Data Bus {ON, payload} for exactly one cycle per grant.
//
// Handshake: a unit raises req[i] with its result on payload[i]. It learns
// it was served only by seeing its own FU tag on cdb with ON=1. It must then
// drop req[i] within half a cycle. There is no stall: consumers take every
// broadcast.
//
// Optional feature: define CDB_ARB_STATS_EN to add the bcast_cnt,
// conflict_cnt and max_wait statistics outputs.

`ifndef NUM_CDBBITS
`define NUM_CDBBITS 39
`endif

module cdb_arbiter #(
  parameter int N_UNITS   = 5,
  parameter int PAYLOAD_W = `NUM_CDBBITS - 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_UNITS-1:0]             req,
  input  logic [N_UNITS*PAYLOAD_W-1:0]   payload,
  output logic [PAYLOAD_W:0]             cdb,
  output logic [N_UNITS-1:0]             grant,
  output logic [N_UNITS-1:0]             pending
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]                    bcast_cnt,
  output logic [31:0]                    conflict_cnt,
  output logic [7:0]                     max_wait
`endif
);

  localparam int PTR_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  logic [N_UNITS-1:0] grant_q;
  logic [PAYLOAD_W:0] cdb_q;
  logic [PTR_W-1:0]   rr_ptr_q;

  // The holdoff mask is the registered grant: a unit shown on the bus this
  // cycle is still asserting req until its negedge logic drops it, so it
  // must sit out the edge ending this cycle.
  logic [N_UNITS-1:0] holdoff;
  logic [N_UNITS-1:0] eligible;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [N_UNITS-1:0] grant_next;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [PAYLOAD_W-1:0] win_payload;

  assign holdoff  = grant_q;
  assign eligible = req & ~holdoff;
  assign pending  = eligible;
  assign grant    = grant_q;
  assign cdb      = cdb_q;

  // Round-robin search over eligible units starting at rr_ptr, wrapping.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N_UNITS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_UNITS) begin
        idx = idx - N_UNITS;
      end
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  // Winner decode: one-hot grant, next pointer and the winner's payload.
  always_comb begin
    grant_next  = '0;
    rr_ptr_next = rr_ptr_q;
    win_payload = payload[int'(win_idx)*PAYLOAD_W +: PAYLOAD_W];
    if (win_found) begin
      grant_next = N_UNITS'(1) << win_idx;
      if (int'(win_idx) == N_UNITS - 1) begin
        rr_ptr_next = '0;
      end else begin
        rr_ptr_next = win_idx + PTR_W'(1);
      end
    end
  end

  // Bus, grant and pointer registers; the payload is captured at the grant
  // edge, and an idle cycle zeroes the whole bus, not only the ON bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_q    <= '0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      grant_q  <= grant_next;
      rr_ptr_q <= rr_ptr_next;
      if (win_found) begin
        cdb_q <= {1'b1, win_payload};
      end else begin
        cdb_q <= '0;
      end
    end
  end

`ifdef CDB_ARB_STATS_EN
  // Per-unit count of consecutive edges with req high and no win there.
  logic [7:0] wait_cnt  [N_UNITS];
  logic [7:0] wait_next [N_UNITS];
  logic [7:0] max_next;

  // Next wait counts (saturating at 255) and the running maximum.
  always_comb begin
    max_next = max_wait;
    for (int i = 0; i < N_UNITS; i++) begin
      wait_next[i] = 8'd0;
      if (req[i] && !grant_next[i]) begin
        wait_next[i] = (wait_cnt[i] == 8'hFF) ? 8'hFF : wait_cnt[i] + 8'd1;
      end
      if (wait_next[i] > max_next) begin
        max_next = wait_next[i];
      end
    end
  end

  // Statistics registers; the 32-bit counters wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcast_cnt    <= '0;
      conflict_cnt <= '0;
      max_wait     <= '0;
      for (int i = 0; i < N_UNITS; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      if (grant_next != '0) begin
        bcast_cnt <= bcast_cnt + 32'd1;
      end
      if ($countones(eligible) >= 2) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
      max_wait <= max_next;
      for (int i = 0; i < N_UNITS; i++) begin
        wait_cnt[i] <= wait_next[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vectors for cdb_arbiter. The driver pushes the
// expected {grant, cdb} for every cycle it drives; a monitor pops one entry
// just after each posedge and compares it with the registered outputs.

module tb_cdb_arbiter;

  localparam int N  = 5;
  localparam int PW = 38;
  localparam int CW = PW + 1;
  localparam int EW = N + CW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*PW-1:0] payload = '0;
  logic [CW-1:0]   cdb;
  logic [N-1:0]    grant;
  logic [N-1:0]    pending;
`ifdef CDB_ARB_STATS_EN
  logic [31:0]     bcast_cnt;
  logic [31:0]     conflict_cnt;
  logic [7:0]      max_wait;
`endif

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  cdb_arbiter #(.N_UNITS(N), .PAYLOAD_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .payload      (payload),
    .cdb          (cdb),
    .grant        (grant),
    .pending      (pending)
`ifdef CDB_ARB_STATS_EN
    ,
    .bcast_cnt    (bcast_cnt),
    .conflict_cnt (conflict_cnt),
    .max_wait     (max_wait)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Unit i payload: FU tag (i+1), RS tag 3'b100, data seed+i.
  function automatic logic [PW-1:0] mk_pl(input int i, input logic [31:0] seed);
    logic [2:0] tag;
    tag = 3'(i + 1);
    return {tag, 3'b100, seed + 32'(i)};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, got, want);
  endtask

  // One driven cycle: inputs change at negedge; w is the hand-computed
  // winner index at the following posedge (-1 = idle bus).
  task automatic cyc(input logic r, input logic [N-1:0] rq, input int w,
                     input logic [31:0] seed, input string nm,
                     input bit chk_pend, input logic [N-1:0] exp_pend);
    logic [EW-1:0] e;
    @(negedge clk);
    rst = r;
    req = rq;
    for (int i = 0; i < N; i++) payload[i*PW +: PW] = mk_pl(i, seed);
    if (w < 0) e = '0;
    else       e = {N'(1) << w, 1'b1, mk_pl(w, seed)};
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (chk_pend) begin
      #1;
      check({nm, "_pending"}, 32'(pending), 32'(exp_pend));
    end
  endtask

  // Monitor: compares one expected entry per posedge.
  initial begin
    logic [EW-1:0] e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if ({grant, cdb} === e) n_pass++;
        else $display("FAIL %s: got grant=%b cdb=%h, want grant=%b cdb=%h",
                      nm, grant, cdb, e[EW-1 -: N], e[CW-1:0]);
      end
    end
  end

  // Directed stimulus
  initial begin
    cyc(1, 5'b00000, -1, 32'h0, "reset0", 0, '0);
    cyc(1, 5'b00000, -1, 32'h0, "reset1", 0, '0);
    // Single requester, then bus returns to 0.
    cyc(0, 5'b00001,  0, 32'h2A,  "single", 1, 5'b00001);
    cyc(0, 5'b00000, -1, 32'h777, "single_idle", 0, '0);
    // Sole requester held three cycles: alternate broadcasts (ptr 1 -> 3).
    cyc(0, 5'b00100,  2, 32'h100, "hold_a", 1, 5'b00100);
    cyc(0, 5'b00100, -1, 32'h200, "hold_b", 1, 5'b00000);
    cyc(0, 5'b00100,  2, 32'h300, "hold_c", 1, 5'b00100);
    cyc(0, 5'b00000, -1, 32'h400, "hold_idle", 0, '0);
    // rr_ptr=3 with req 01001: unit 3 then unit 0 (ptr -> 1).
    cyc(0, 5'b01001,  3, 32'h500, "rr3_first", 0, '0);
    cyc(0, 5'b01001,  0, 32'h600, "rr3_second", 1, 5'b00001);
    cyc(0, 5'b00000, -1, 32'h700, "rr3_idle", 0, '0);
    // Move ptr to 4, then req 10001: unit 4 before unit 0 (wrap).
    cyc(0, 5'b01000,  3, 32'h800, "wrap_setup", 0, '0);
    cyc(0, 5'b00000, -1, 32'h900, "wrap_gap", 0, '0);
    cyc(0, 5'b10001,  4, 32'hA00, "wrap_first", 0, '0);
    cyc(0, 5'b10001,  0, 32'hB00, "wrap_second", 0, '0);
    cyc(0, 5'b00000, -1, 32'hC00, "wrap_idle", 0, '0);
    // Reset on the same edge as a request; restart from unit 0.
    cyc(1, 5'b00010, -1, 32'hD00, "rst_req", 0, '0);
    cyc(0, 5'b00011,  0, 32'hE00, "post_rst_0", 0, '0);
    cyc(0, 5'b00011,  1, 32'hF00, "post_rst_1", 0, '0);
    cyc(0, 5'b00000, -1, 32'h1000, "post_rst_idle", 0, '0);
    // Reset mid-broadcast drops the bus (ptr 2 here).
    cyc(0, 5'b00100,  2, 32'h1100, "mid_bcast", 0, '0);
    cyc(1, 5'b00100, -1, 32'h1200, "mid_rst", 0, '0);
    // All five continuously from reset: 0,1,2,3,4,0,... no idle cycles.
    for (int i = 0; i < 10; i++)
      cyc(0, 5'b11111, i % 5, 32'h2000 + 32'(i*16), $sformatf("all5_%0d", i), 0, '0);
    cyc(0, 5'b00000, -1, 32'h3000, "all5_idle", 0, '0);
`ifdef CDB_ARB_STATS_EN
    // Fresh reset, then four cycles of req 00011: wins 0,1,0,1. Both are
    // eligible only on the first edge (holdoff masks one afterwards).
    cyc(1, 5'b00000, -1, 32'h0, "st_rst", 0, '0);
    cyc(0, 5'b00011,  0, 32'h4000, "st_0", 0, '0);
    cyc(0, 5'b00011,  1, 32'h4100, "st_1", 0, '0);
    cyc(0, 5'b00011,  0, 32'h4200, "st_2", 0, '0);
    cyc(0, 5'b00011,  1, 32'h4300, "st_3", 0, '0);
    @(posedge clk);
    #2;
    check("bcast_cnt", bcast_cnt, 32'd4);
    check("conflict_cnt", conflict_cnt, 32'd1);
    check("max_wait", 32'(max_wait), 32'd1);
    cyc(0, 5'b00000, -1, 32'h0, "st_idle", 0, '0);
`endif
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
